// File: rtl/split_pkg.sv
// Opcode table and classification shared by the split_n_sync fork.
package split_pkg;

  localparam logic [6:0] R_type    = 7'b0110011;
  localparam logic [6:0] I_type_op = 7'b0010011;
  localparam logic [6:0] I_type_ld = 7'b0000011;
  localparam logic [6:0] U_type    = 7'b0110111;
  localparam logic [6:0] B_type    = 7'b1100011;
  localparam logic [6:0] J_type    = 7'b1101111;
  localparam logic [6:0] S_type    = 7'b0100011;
  localparam logic [6:0] NOP_type  = 7'b0000000;

  typedef enum logic [1:0] {CLS_BJ, CLS_LDST, CLS_ALU, CLS_ILLEGAL} op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      B_type, J_type:                      cls = CLS_BJ;
      I_type_ld, S_type:                   cls = CLS_LDST;
      R_type, I_type_op, NOP_type, U_type: cls = CLS_ALU;
      default:                             cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/split_fifo.sv
// Per-channel first-word-fall-through FIFO; a push while full is allowed only alongside a pop.
module split_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_count   = r_cnt;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);
  // Gate the head so stale storage never shows on an empty channel.
  assign o_head    = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/split_n_sync.sv
// Opcode-directed fork: routes each accepted token to its class's channel FIFO, drops and counts illegal ones.
module split_n_sync
  import split_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2,
  parameter int CH_BJ   = 0,
  parameter int CH_LDST = 1,
  parameter int CH_ALU  = 2,
  parameter int ERR_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_opcode,
  input  logic [DATA_W-1:0]      in_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*7-1:0]      out_opcode,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   busy,
  output logic                   err_pulse,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int TOK_W  = 7 + DATA_W;
  localparam int DEST_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  op_class_e         w_cls;
  logic              w_illegal;
  logic [DEST_W-1:0] w_dest;
  logic              w_accept;
  logic [N_CH-1:0]   w_full;
  logic [N_CH-1:0]   w_empty;
  logic [N_CH-1:0]   w_pop;
  logic [N_CH-1:0]   w_push;
  logic [N_CH-1:0]   w_nonzero;
  logic [TOK_W-1:0]  w_head  [N_CH];
  logic [CNT_W-1:0]  w_count [N_CH];
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_cnt;

  assign w_cls     = classify(in_opcode);
  assign w_illegal = (w_cls == CLS_ILLEGAL);

  always_comb begin
    w_dest = '0;
    case (w_cls)
      CLS_BJ:   w_dest = DEST_W'(CH_BJ);
      CLS_LDST: w_dest = DEST_W'(CH_LDST);
      CLS_ALU:  w_dest = DEST_W'(CH_ALU);
      default:  w_dest = '0;
    endcase
  end

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  // A full channel still accepts when its head leaves this same cycle.
  assign in_ready  = ~flush & (w_illegal | ~w_full[w_dest] | w_pop[w_dest]);
  assign w_accept  = in_valid & in_ready;
  assign busy      = |w_nonzero;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_push[gi]    = w_accept & ~w_illegal & (w_dest == DEST_W'(gi));
    assign w_nonzero[gi] = |w_count[gi];

    split_fifo #(
      .WIDTH (TOK_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push[gi]),
      .i_pop   (w_pop[gi]),
      .i_data  ({in_opcode, in_data}),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_count (w_count[gi]),
      .o_head  (w_head[gi])
    );

    assign out_opcode[gi*7 +: 7]          = w_head[gi][TOK_W-1:DATA_W];
    assign out_data[gi*DATA_W +: DATA_W]  = w_head[gi][DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_accept & w_illegal;
      if (w_accept && w_illegal && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_split_n_sync.sv
// Randomised and directed bench for split_n_sync against a queue-based reference model.
module tb_split_n_sync;

  localparam int N_CH  = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid;
  logic [6:0]       in_opcode;
  logic [DW-1:0]    in_data;
  logic [N_CH-1:0]  out_ready;
  logic             in_ready, busy, err_pulse;
  logic [N_CH-1:0]  out_valid;
  logic [N_CH*7-1:0]  out_opcode;
  logic [N_CH*DW-1:0] out_data;
  logic [7:0]       err_cnt;
  logic             d2_in_ready, d2_busy, d2_err_pulse;
  logic [N_CH-1:0]  d2_out_valid;
  logic [N_CH*7-1:0]  d2_out_opcode;
  logic [N_CH*DW-1:0] d2_out_data;
  logic [1:0]       d2_err_cnt;

  always #5 clk = ~clk;

  split_n_sync #(.ERR_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_data(out_data), .busy(busy), .err_pulse(err_pulse),
    .err_cnt(err_cnt)
  );

  split_n_sync #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_opcode(in_opcode), .in_data(in_data), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_opcode(d2_out_opcode), .out_data(d2_out_data), .busy(d2_busy), .err_pulse(d2_err_pulse),
    .err_cnt(d2_err_cnt)
  );

  typedef struct { logic [6:0] op; logic [DW-1:0] d; } tok_t;
  tok_t q [N_CH][$];
  int   mdl_err8, mdl_err2;
  bit   mdl_pulse;
  bit   exp_rdy;
  logic obs_ready;
  bit   chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  function automatic int dest_of(input logic [6:0] op);
    case (op)
      7'b1100011, 7'b1101111:                         return 0;
      7'b0000011, 7'b0100011:                         return 1;
      7'b0110011, 7'b0010011, 7'b0000000, 7'b0110111: return 2;
      default:                                        return -1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the model state for the current cycle.
  task automatic compare();
    logic [N_CH-1:0] ev;
    int d;
    bit any;
    any = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      ev[c] = (q[c].size() != 0);
      any |= ev[c];
    end
    d = dest_of(in_opcode);
    if (flush)       exp_rdy = 1'b0;
    else if (d < 0)  exp_rdy = 1'b1;
    else             exp_rdy = (q[d].size() < DEPTH) || (q[d].size() > 0 && out_ready[d]);
    obs_ready = in_ready;
    if (!chk_en) return;
    chk("out_valid", out_valid, ev);
    chk("d2_out_valid", d2_out_valid, ev);
    chk("busy", busy, any);
    chk("d2_busy", d2_busy, any);
    chk("in_ready", in_ready, exp_rdy);
    chk("d2_in_ready", d2_in_ready, exp_rdy);
    chk("err_pulse", err_pulse, mdl_pulse);
    chk("d2_err_pulse", d2_err_pulse, mdl_pulse);
    chk("err_cnt", err_cnt, mdl_err8);
    chk("d2_err_cnt", d2_err_cnt, mdl_err2);
    for (int c = 0; c < N_CH; c++) begin
      if (ev[c]) begin
        chk("out_data", out_data[c*DW +: DW], q[c][0].d);
        chk("out_opcode", out_opcode[c*7 +: 7], q[c][0].op);
        chk("d2_out_data", d2_out_data[c*DW +: DW], q[c][0].d);
      end
    end
  endtask

  task automatic update();
    int d;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) q[c].delete();
      mdl_err8 = 0; mdl_err2 = 0; mdl_pulse = 1'b0;
    end else if (flush) begin
      for (int c = 0; c < N_CH; c++) q[c].delete();
      mdl_pulse = 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (q[c].size() > 0 && out_ready[c]) void'(q[c].pop_front());
      mdl_pulse = 1'b0;
      if (in_valid && exp_rdy) begin
        d = dest_of(in_opcode);
        if (d < 0) begin
          mdl_pulse = 1'b1;
          if (mdl_err8 < 255) mdl_err8++;
          if (mdl_err2 < 3)   mdl_err2++;
        end else begin
          q[d].push_back('{op: in_opcode, d: in_data});
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic v, input logic [6:0] op,
                       input logic [DW-1:0] dat, input logic [N_CH-1:0] rdy);
    rst = r; flush = f; in_valid = v; in_opcode = op; in_data = dat; out_ready = rdy;
    #1;
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal [8];
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
              7'b1100011, 7'b1101111, 7'b0100011, 7'b0000000};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = '0; in_data = '0; out_ready = '0;
    @(negedge clk);
    cycle(1, 0, 0, 7'h00, 0, 3'b111);
    chk_en = 1'b1;

    // Reset state
    chk("rst_out_valid", out_valid, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_out_data", out_data, 96'd0);
    chk("rst_out_opcode", out_opcode, 21'd0);

    // B_type routes to channel 0 with one cycle of latency
    cycle(0, 0, 1, 7'b1100011, 32'hA5, 3'b111);
    chk("bj_valid", out_valid, 3'b001);
    chk("bj_data", out_data[31:0], 32'hA5);

    // Channel 1 stalled: third store blocked, ALU token still passes
    cycle(0, 0, 1, 7'b0100011, 32'h10, 3'b101);
    cycle(0, 0, 1, 7'b0100011, 32'h11, 3'b101);
    cycle(0, 0, 1, 7'b0100011, 32'h12, 3'b101);
    chk("full_stall", obs_ready, 1'b0);
    cycle(0, 0, 1, 7'b0110011, 32'h20, 3'b101);
    chk("alu_bypass_ready", obs_ready, 1'b1);
    chk("alu_valid", out_valid[2], 1'b1);
    chk("alu_data", out_data[95:64], 32'h20);

    // Push into a full channel while its head pops
    cycle(0, 0, 1, 7'b0000011, 32'h12, 3'b111);
    chk("full_pop_ready", obs_ready, 1'b1);
    chk("order_d1", out_data[63:32], 32'h11);
    cycle(0, 0, 0, 7'h00, 0, 3'b111);
    chk("order_d2", out_data[63:32], 32'h12);
    cycle(0, 0, 0, 7'h00, 0, 3'b111);
    chk("drained", out_valid, 3'b000);

    // Illegal opcodes
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 7'b1111111, i, 3'b111);
      chk("ill_pulse", err_pulse, 1'b1);
    end
    chk("ill_cnt3", err_cnt, 8'd3);
    chk("ill_none_valid", out_valid, 3'b000);
    cycle(0, 0, 1, 7'b1111111, 0, 3'b111);
    cycle(0, 0, 1, 7'b1111111, 0, 3'b111);
    chk("ill_cnt5", err_cnt, 8'd5);
    chk("ill_sat", d2_err_cnt, 2'd3);
    cycle(0, 0, 0, 7'h00, 0, 3'b111);
    chk("ill_pulse_low", err_pulse, 1'b0);

    // Flush keeps err_cnt and drops the flush-cycle token
    cycle(0, 0, 1, 7'b1100011, 32'h1, 3'b000);
    cycle(0, 0, 1, 7'b1101111, 32'h2, 3'b000);
    cycle(0, 0, 1, 7'b0110011, 32'h3, 3'b000);
    cycle(0, 0, 1, 7'b0110111, 32'h4, 3'b000);
    chk("pre_flush_valid", out_valid, 3'b101);
    cycle(0, 1, 1, 7'b0110011, 32'h5, 3'b000);
    chk("flush_valid", out_valid, 3'b000);
    chk("flush_busy", busy, 1'b0);
    chk("flush_err_cnt", err_cnt, 8'd5);
    cycle(0, 0, 0, 7'h00, 0, 3'b000);
    chk("flush_token_absent", out_valid, 3'b000);

    // Reset mid-operation, then NOP goes to channel 2
    cycle(0, 0, 1, 7'b1100011, 32'h6, 3'b000);
    cycle(0, 0, 1, 7'b0100011, 32'h7, 3'b000);
    cycle(0, 0, 1, 7'b0010011, 32'h8, 3'b000);
    cycle(1, 0, 1, 7'b0110011, 32'h9, 3'b000);
    chk("rst_mid_valid", out_valid, 3'b000);
    chk("rst_mid_err", err_cnt, 8'd0);
    chk("rst_mid_busy", busy, 1'b0);
    cycle(0, 0, 1, 7'b0000000, 32'h77, 3'b111);
    chk("nop_valid", out_valid, 3'b100);
    chk("nop_data", out_data[95:64], 32'h77);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, f, v;
      logic [6:0] op;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 7);
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal[$urandom_range(0, 7)];
      cycle(r, f, v, op, $urandom, 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/split_n_sync.md
Name: split_n_sync

Overview:
- Clocked, parametrised opcode-directed fork. It accepts one instruction token per cycle on a valid/ready input and routes it by opcode class to one of N_CH output channels.
- Each channel has its own DEPTH-entry FIFO, so a stalled consumer does not block traffic bound for other channels.
- Illegal opcodes are dropped and counted.
- Sits between decode and the execution-unit issue ports.

Parameters:
- N_CH, 3, number of output channels (≥3).
- DATA_W, 32, token payload width.
- DEPTH, 2, per-channel FIFO depth; power of two, ≥2.
- CH_BJ, 0, channel index for B_type/J_type.
- CH_LDST, 1, channel index for I_type_ld/S_type.
- CH_ALU, 2, channel index for R_type/I_type_op/NOP_type/U_type.
- ERR_W, 8, width of illegal-opcode counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all FIFOs; counter kept.
- in_valid  in  1  input token valid.
- in_ready  out  1  input accepted this cycle when in_valid&in_ready.
- in_opcode  in  7  opcode used for routing.
- in_data  in  DATA_W  payload.
- out_valid  out  N_CH  per-channel head valid.
- out_ready  in  N_CH  per-channel consumer ready.
- out_opcode  out  N_CH*7  per-channel head opcode, channel c at [7c+6:7c].
- out_data  out  N_CH*DATA_W  per-channel head payload.
- busy  out  1  any FIFO non-empty.
- err_pulse  out  1  one-cycle pulse on illegal-opcode drop.
- err_cnt  out  ERR_W  saturating count of dropped tokens.

Behaviour:
- Reset (rst=1 at clk edge): all FIFOs empty, so out_valid=0, busy=0, err_pulse=0, err_cnt=0. out_data/out_opcode are 0 after reset.
- rst has priority over flush.
- Decode (combinational): dest = channel index per class parameters.
  - Opcodes not in the opcode package table are illegal.
  - Channels not named by any CH_* receive no traffic; their out_valid stays 0.
- in_ready:
  - in_ready = illegal(in_opcode) | ~full[dest] | out_pop[dest].
  - The out_pop term is a same-cycle pop of the full channel's head (bypass-free: the new token enters the freed slot at the tail).
  - in_ready depends combinationally on in_opcode and out_ready; upstream must hold opcode stable while in_valid=1.
  - in_ready=0 during flush.
- Push: on in_valid&in_ready with a legal opcode, write {opcode,data} to FIFO[dest] tail. It is visible at out_valid[dest] the next cycle (latency 1, no same-cycle pass-through).
- Illegal token: on in_valid&in_ready with an illegal opcode:
  - The token is discarded.
  - err_pulse=1 in the next cycle.
  - err_cnt increments and saturates at 2^ERR_W-1.
- Pop: out_valid[c]&out_ready[c] advances channel c head. Channels are independent; several can pop in one cycle.
- Simultaneous push and pop on the same channel: occupancy is unchanged. Legal when the FIFO is full (via the out_pop term) and when it has one entry.
- Ordering: FIFO order within a channel. No ordering guarantee across channels.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits; full = count==DEPTH, empty = count==0.
- flush=1: all counts and pointers go to 0 at the edge. Any push or pop in that cycle is ignored. err_cnt is preserved.
- Reset mid-operation: in-flight tokens are lost. No output glitches beyond out_valid falling to 0 at the next edge.
- out_valid[c]=~empty[c]. busy=|(~empty).
- Per-channel FIFO state: EMPTY → PARTIAL → FULL, transitions driven by net push−pop.

Decomposition:
- Package split_pkg:
  - opcode localparams R_type=0110011, I_type_op=0010011, I_type_ld=0000011, U_type=0110111, B_type=1100011, J_type=1101111, S_type=0100011, NOP_type=0000000.
  - enum op_class_e {CLS_BJ, CLS_LDST, CLS_ALU, CLS_ILLEGAL}.
  - function classify(opcode).
- One sub-module, split_fifo (parameters WIDTH, DEPTH; push/pop/flush, full/empty/count, head data), instantiated N_CH times by generate.

Test Plan:
- Reset, then opcode 1100011, data 0xA5 with all out_ready=1 → out_valid=3'b001 one cycle later, out_data[31:0]=0xA5; other channels stay idle.
- out_ready[1]=0, push three S_type (0100011) tokens, DEPTH=2 → first two accepted; in_ready=0 on the third. An interleaved R_type token is still accepted and emerges on channel 2.
- Channel 1 full, then out_ready[1]=1 while pushing a load → in_ready=1. Count stays 2, and tokens emerge in order D0, D1, D2.
- Push opcode 1111111 three times → no out_valid, err_pulse high once per token, err_cnt=3. With ERR_W=2, five drops → err_cnt=3 (saturated).
- Fill channels 0 and 2, assert flush for one cycle with in_valid=1 → next cycle out_valid=0, busy=0, flushed-cycle token absent, err_cnt unchanged.
- Assert rst while all FIFOs hold tokens and push in the same cycle → next cycle all outputs at reset values; the subsequent push of NOP (0000000) exits on channel 2 after one cycle.
